taylor_series_stage: RTL and testbench

//  Stage 4 of the exponential pipeline, directly upstream of the output process stage.

---
 rtl/exp_pkg.sv | 39 +++
 rtl/fixed_mul.sv | 19 +
 rtl/taylor_series_stage.sv | 121 ++++++++++++
 tb/tb_taylor_series_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared constants and helpers for the exponential pipeline.
// Q2.24 fixed point: 1.0 is 1 << FRAC_W.
package exp_pkg;

    localparam int W      = 26;
    localparam int FRAC_W = 24;

    localparam logic [W-1:0] ONE_FIXED = 26'h1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_F = 2'd1,
        MUL_R = 2'd2,
        DONE  = 2'd3
    } state_t;

    // floor(2^24 / k) as a Q2.24 operand; k = 1 needs the full 1.0
    function automatic logic [W-1:0] recip(input logic [3:0] k);
        logic [W-1:0] r;
        r = '0;
        case (k)
            4'd1:    r = 26'h1000000;
            4'd2:    r = 26'h0800000;
            4'd3:    r = 26'h0555555;
            4'd4:    r = 26'h0400000;
            4'd5:    r = 26'h0333333;
            4'd6:    r = 26'h02AAAAA;
            4'd7:    r = 26'h0249249;
            4'd8:    r = 26'h0200000;
            4'd9:    r = 26'h01C71C7;
            4'd10:   r = 26'h0199999;
            4'd11:   r = 26'h01745D1;
            4'd12:   r = 26'h0155555;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fixed_mul.sv
// Unsigned Q2.24 x Q2.24 multiply, truncated back to Q2.24.
// The accumulator stays below 2.72, so the top product bits are always 0.
module fixed_mul
    import exp_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic [2*W-1:0] full;
    logic           unused_bits;

    assign full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign p    = full[FRAC_W+W-1:FRAC_W];

    assign unused_bits = ^{full[2*W-1:FRAC_W+W], full[FRAC_W-1:0]};

endmodule

// File: rtl/taylor_series_stage.sv
// Stage 4: e^f for 0 <= f < 1 by Horner evaluation of the Taylor series,
// acc = 1 + acc*f/k for k = TERMS..1, on a single shared multiplier.
module taylor_series_stage
    import exp_pkg::*;
#(
    parameter int TERMS = 8
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] FIXED_frac_input,
    input  logic [W-1:0] FIXED_e_input,
    input  logic [31:0]  FLOAT_e_input,
    output logic [W-1:0] FIXED_taylor_output,
    output logic [W-1:0] FIXED_e_output,
    output logic [31:0]  FLOAT_e_output,
    output logic         output_ready,
    output logic         busy
);

    localparam logic [3:0] K_INIT = 4'(TERMS);

    state_t       state;
    state_t       state_nx;
    logic [3:0]   k;
    logic [W-1:0] f_reg;
    logic [W-1:0] acc;
    logic [W-1:0] prod;
    logic [W-1:0] e_fixed;
    logic [31:0]  e_float;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_p;
    logic [W-1:0] acc_nx;
    logic         last;
    logic         unused_frac_hi;

    assign unused_frac_hi = ^FIXED_frac_input[W-1:FRAC_W];

    assign last   = (k == 4'd1);
    assign acc_nx = ONE_FIXED + mul_p;
    assign busy   = (state != IDLE);

    // State register
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state: two multiply phases per series term
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = MUL_F;
            MUL_F:   state_nx = MUL_R;
            MUL_R:   state_nx = last ? DONE : MUL_F;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Multiplier operand select: acc*f, then prod*(1/k)
    always_comb begin
        mul_a = acc;
        mul_b = f_reg;
        if (state == MUL_R) begin
            mul_a = prod;
            mul_b = recip(k);
        end
    end

    fixed_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Datapath and output registers
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            k                   <= '0;
            f_reg               <= '0;
            acc                 <= '0;
            prod                <= '0;
            e_fixed             <= '0;
            e_float             <= '0;
            FIXED_taylor_output <= '0;
            FIXED_e_output      <= '0;
            FLOAT_e_output      <= '0;
            output_ready        <= 1'b0;
        end else begin
            output_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        f_reg   <= {2'b00, FIXED_frac_input[FRAC_W-1:0]};
                        e_fixed <= FIXED_e_input;
                        e_float <= FLOAT_e_input;
                        acc     <= ONE_FIXED;
                        k       <= K_INIT;
                    end
                end
                MUL_F: prod <= mul_p;
                MUL_R: begin
                    acc <= acc_nx;
                    if (last) begin
                        FIXED_taylor_output <= acc_nx;
                        FIXED_e_output      <= e_fixed;
                        FLOAT_e_output      <= e_float;
                        output_ready        <= 1'b1;
                    end else begin
                        k <= k - 4'd1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_taylor_series_stage.sv
// Directed bench for taylor_series_stage.
// Expected values are constants or a real-valued series model.
module tb_taylor_series_stage;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [25:0] FIXED_frac_input = '0;
    logic [25:0] FIXED_e_input = '0;
    logic [31:0] FLOAT_e_input = '0;
    logic [25:0] FIXED_taylor_output;
    logic [25:0] FIXED_e_output;
    logic [31:0] FLOAT_e_output;
    logic        output_ready;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    taylor_series_stage dut (
        .CLK                 (CLK),
        .rst                 (rst),
        .start               (start),
        .FIXED_frac_input    (FIXED_frac_input),
        .FIXED_e_input       (FIXED_e_input),
        .FLOAT_e_input       (FLOAT_e_input),
        .FIXED_taylor_output (FIXED_taylor_output),
        .FIXED_e_output      (FIXED_e_output),
        .FLOAT_e_output      (FLOAT_e_output),
        .output_ready        (output_ready),
        .busy                (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [25:0] got,
                              input int exp, input int tol);
        int d;
        d = int'(got) - exp;
        n_cmp++;
        assert (d >= -tol && d <= tol) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d",
                   tag, got, exp, tol);
        end
    endtask

    // 8-term series in reals; truncation only lowers the hardware result
    function automatic real series(input logic [23:0] f);
        real x;
        real p;
        x = real'(f) / 16777216.0;
        p = 1.0;
        for (int j = 8; j >= 1; j--) p = 1.0 + p * x / real'(j);
        return p * 16777216.0;
    endfunction

    task automatic check_model(input string tag, input logic [25:0] got,
                               input real m);
        real err;
        err = real'(int'(got)) - m;
        n_cmp++;
        assert (err <= 1.0 && err >= -16.0) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0f (-16..+1)",
                   tag, got, m);
        end
    endtask

    // Issue one operation and return the cycle the strobe appears in
    task automatic run_op(input logic [25:0] f, input logic [25:0] ef,
                          input logic [31:0] efl, output int lat);
        @(negedge CLK);
        FIXED_frac_input = f;
        FIXED_e_input    = ef;
        FLOAT_e_input    = efl;
        start            = 1'b1;
        @(negedge CLK);
        start            = 1'b0;
        FIXED_frac_input = ~f;
        FIXED_e_input    = 26'h3A5A5A5;
        FLOAT_e_input    = 32'hDEADBEEF;
        lat = 1;
        while (!output_ready && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int strobes;
        int first_s;
        int second_s;
        int wait_c;
        bit busy_seen;
        logic [25:0] rf;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_taylor", 32'(FIXED_taylor_output), 32'h0);
        check("rst_efix", 32'(FIXED_e_output), 32'h0);
        check("rst_eflt", FLOAT_e_output, 32'h0);
        check("rst_ready", 32'(output_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;

        // f = 0: exactly 1.0, strobe in cycle 17 for one cycle
        run_op(26'h0000000, 26'h0000001, 32'h3F800000, lat);
        check("f0_lat", 32'(lat), 32'd17);
        check("f0_taylor", 32'(FIXED_taylor_output), 32'h1000000);
        @(negedge CLK);
        check("f0_strobe_1cyc", 32'(output_ready), 32'h0);
        check("f0_idle", 32'(busy), 32'h0);

        // f = 0.5: e^0.5 * 2^24 = 27660952.9 (0x1A61299)
        run_op(26'h0800000, 26'h2B7E151, 32'h402DF854, lat);
        check("half_lat", 32'(lat), 32'd17);
        check_near("half_taylor", FIXED_taylor_output, 27660953, 16);
        check("half_efix", 32'(FIXED_e_output), 32'h2B7E151);
        check("half_eflt", FLOAT_e_output, 32'h402DF854);

        // f = 1-2^-24: 8-term sum is 45605147.4 (0x2B7E11B),
        // about 51 LSB below e itself because of the series tail
        run_op(26'h0FFFFFF, 26'h1234567, 32'h40000000, lat);
        check("max_lat", 32'(lat), 32'd17);
        check_near("max_taylor", FIXED_taylor_output, 45605147, 16);

        // Integer bits of f are masked off
        run_op(26'h3FFFFFF, 26'h0ABCDEF, 32'h41200000, lat);
        check("mask_lat", 32'(lat), 32'd17);
        check_near("mask_taylor", FIXED_taylor_output, 45605147, 16);
        check("mask_efix", 32'(FIXED_e_output), 32'h0ABCDEF);

        // Start held for 40 cycles: two results, 18 cycles apart
        @(negedge CLK);
        FIXED_frac_input = 26'h0800000;
        start = 1'b1;
        strobes = 0;
        first_s = 0;
        second_s = 0;
        busy_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (busy) busy_seen = 1'b1;
            if (output_ready) begin
                strobes++;
                if (strobes == 1) first_s = i;
                if (strobes == 2) second_s = i;
            end
        end
        start = 1'b0;
        check("hold_count", 32'(strobes), 32'd2);
        check("hold_first", 32'(first_s), 32'd17);
        check("hold_gap", 32'(second_s - first_s), 32'd18);
        check("hold_busy", 32'(busy_seen), 32'h1);
        wait_c = 0;
        while (busy && wait_c < 40) begin
            @(negedge CLK);
            wait_c++;
        end
        check("hold_drain", 32'(busy), 32'h0);
        check_near("hold_taylor", FIXED_taylor_output, 27660953, 16);

        // Reset at cycle 7 of an operation aborts it
        @(negedge CLK);
        FIXED_frac_input = 26'h0FFFFFF;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (6) @(negedge CLK);
        #1 rst = 1'b0;
        #1;
        check("abort_taylor", 32'(FIXED_taylor_output), 32'h0);
        check("abort_efix", 32'(FIXED_e_output), 32'h0);
        check("abort_eflt", FLOAT_e_output, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge CLK);
        rst = 1'b1;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (output_ready) strobes++;
        end
        check("abort_nostrobe", 32'(strobes), 32'd0);
        run_op(26'h0800000, 26'h0000123, 32'h3F000000, lat);
        check("after_lat", 32'(lat), 32'd17);
        check_near("after_taylor", FIXED_taylor_output, 27660953, 16);
        check("after_efix", 32'(FIXED_e_output), 32'h0000123);

        // Random sweep against the real-valued series
        for (int i = 0; i < 1000; i++) begin
            rf = 26'($urandom);
            run_op(rf, 26'(i), 32'(i), lat);
            if (lat != 17) check("sweep_lat", 32'(lat), 32'd17);
            check_model("sweep", FIXED_taylor_output, series(rf[23:0]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
